// File: rtl/spi_shift_reg.sv
// Addressed serial/parallel shift register with bit counter, frame-complete pulse
// and abort-on-deselect. Instances share the bus; only the one whose ID matches RSELIN acts.
module spi_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int ID_BITS   = 2,
  parameter int ID        = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DI,
  input  logic               EN,
  input  logic               LOAD,
  input  logic [WIDTH-1:0]   PLD,
  input  logic [ID_BITS-1:0] RSELIN,
  output logic               DO,
  output logic [WIDTH-1:0]   POUT,
  output logic               READY,
  output logic               BUSY
);

  localparam int          CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;
  logic             tap;
  logic             sel;

  assign sel = (RSELIN == ID_BITS'(ID));

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {data[WIDTH-2:0], DI};
      assign tap     = data[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {DI, data[WIDTH-1:1]};
      assign tap     = data[0];
    end
  endgenerate

  // DO is forced low when deselected so instances can be wire-ORed
  assign DO   = sel & tap;
  assign POUT = data;
  assign BUSY = (state == SHIFT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      READY <= 1'b0;
    end else begin
      READY <= 1'b0;
      case (state)
        IDLE: begin
          if (sel && LOAD) begin
            data <= PLD;
          end else if (sel && EN) begin
            data  <= shifted;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // deselect mid-frame drops the frame but keeps the partial data
          if (!sel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (EN) begin
            data <= shifted;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= IDLE;
              READY <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_reg.sv
// Directed + randomized bench for spi_shift_reg; MSB-first and LSB-first instances
// share the bus and are compared each cycle against a frame-level reference model.
module tb_spi_shift_reg;

  logic       CLK = 1'b0;
  logic       RST, DI, EN, LOAD;
  logic [7:0] PLD;
  logic [1:0] RSELIN;
  logic       do_m, rdy_m, busy_m, do_l, rdy_l, busy_l;
  logic [7:0] pout_m, pout_l;

  always #5 CLK = ~CLK;

  spi_shift_reg #(.WIDTH(8), .ID_BITS(2), .ID(2), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .DI(DI), .EN(EN), .LOAD(LOAD), .PLD(PLD), .RSELIN(RSELIN),
    .DO(do_m), .POUT(pout_m), .READY(rdy_m), .BUSY(busy_m));

  spi_shift_reg #(.WIDTH(8), .ID_BITS(2), .ID(2), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .DI(DI), .EN(EN), .LOAD(LOAD), .PLD(PLD), .RSELIN(RSELIN),
    .DO(do_l), .POUT(pout_l), .READY(rdy_l), .BUSY(busy_l));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  // reference model: frame-level view (bits received so far out of 8)
  logic [7:0] md_m, md_l;
  bit         m_busy, m_ready, live;
  int         m_bits;
  int         n_busy, n_rdy, rdy_at, cyc_idx;

  task automatic model_edge();
    bit s;
    s = (RSELIN == 2'd2);
    m_ready = 1'b0;
    if (RST) begin
      md_m = 8'h00; md_l = 8'h00; m_busy = 1'b0; m_bits = 0; live = 1'b1;
    end else if (!m_busy) begin
      if (s && LOAD) begin
        md_m = PLD; md_l = PLD;
      end else if (s && EN) begin
        md_m = (md_m << 1) | 8'(DI);
        md_l = (md_l >> 1) | (8'(DI) << 7);
        m_bits = 1; m_busy = 1'b1;
      end
    end else if (!s) begin
      m_busy = 1'b0; m_bits = 0;
    end else if (EN) begin
      md_m = (md_m << 1) | 8'(DI);
      md_l = (md_l >> 1) | (8'(DI) << 7);
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0; m_busy = 1'b0; m_ready = 1'b1;
      end
    end
  endtask

  // one clock: check DO before the edge, registered outputs just after it
  task automatic cyc();
    #1;
    if (live) begin
      chk("do_msb", 32'(do_m), (RSELIN == 2'd2) ? 32'(md_m[7]) : 32'd0);
      chk("do_lsb", 32'(do_l), (RSELIN == 2'd2) ? 32'(md_l[0]) : 32'd0);
    end
    @(posedge CLK);
    model_edge();
    #1;
    cyc_idx++;
    if (busy_m) n_busy++;
    if (rdy_m) begin n_rdy++; rdy_at = cyc_idx; end
    if (live) begin
      chk("pout_msb",  32'(pout_m), 32'(md_m));
      chk("pout_lsb",  32'(pout_l), 32'(md_l));
      chk("ready_msb", 32'(rdy_m),  32'(m_ready));
      chk("ready_lsb", 32'(rdy_l),  32'(m_ready));
      chk("busy_msb",  32'(busy_m), 32'(m_busy));
      chk("busy_lsb",  32'(busy_l), 32'(m_busy));
    end
  endtask

  task automatic quiet();
    RST = 1'b0; EN = 1'b0; LOAD = 1'b0; DI = 1'b0; RSELIN = 2'd2;
  endtask

  task automatic clr_cnt();
    n_busy = 0; n_rdy = 0; rdy_at = -1; cyc_idx = 0;
  endtask

  task automatic load(input logic [7:0] v);
    RSELIN = 2'd2; LOAD = 1'b1; EN = 1'b0; PLD = v;
    cyc();
    LOAD = 1'b0;
  endtask

  task automatic shift(input logic b);
    EN = 1'b1; DI = b;
    cyc();
    EN = 1'b0;
  endtask

  logic [7:0] t3_di;
  logic [7:0] t3_do;

  initial begin
    live = 1'b0; clr_cnt();
    md_m = '0; md_l = '0; m_busy = 1'b0; m_ready = 1'b0; m_bits = 0;
    @(posedge CLK); #1;

    // 1: reset with garbage on the bus
    RST = 1'b1; EN = 1'b1; LOAD = 1'b1; DI = 1'b1; PLD = 8'hFF; RSELIN = 2'd2;
    cyc();
    chk("rst_pout", 32'(pout_m), 32'h00);
    chk("rst_ready", 32'(rdy_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    quiet();
    #1 chk("rst_do", 32'(do_m), 32'd0);

    // 2: load selected, then load addressed elsewhere
    load(8'hA5);
    chk("load_sel", 32'(pout_m), 32'hA5);
    RSELIN = 2'd1; LOAD = 1'b1; PLD = 8'h3C;
    cyc();
    chk("load_unsel", 32'(pout_m), 32'hA5);
    chk("do_unsel", 32'(do_m), 32'd0);
    quiet();

    // 3: full frame
    t3_di = 8'b1011_0001;
    t3_do = 8'b1010_0101;
    load(8'hA5);
    clr_cnt();
    for (int i = 7; i >= 0; i--) begin
      EN = 1'b1; DI = t3_di[i];
      #1;
      chk("t3_do_msb", 32'(do_m), 32'(t3_do[i]));
      chk("t3_do_lsb", 32'(do_l), 32'(t3_do[7-i]));
      cyc();
    end
    quiet();
    cyc();
    chk("t3_pout_msb", 32'(pout_m), 32'hB1);
    chk("t3_pout_lsb", 32'(pout_l), 32'h8D);
    chk("t3_ready_cnt", 32'(n_rdy), 32'd1);
    chk("t3_ready_at", 32'(rdy_at), 32'd8);
    chk("t3_busy_cnt", 32'(n_busy), 32'd7);

    // 4: pause after bit 4
    load(8'hA5);
    clr_cnt();
    for (int i = 7; i >= 0; i--) begin
      shift(t3_di[i]);
      if (i == 4) repeat (3) cyc();
    end
    cyc();
    chk("t4_pout", 32'(pout_m), 32'hB1);
    chk("t4_ready_cnt", 32'(n_rdy), 32'd1);
    chk("t4_ready_at", 32'(rdy_at), 32'd11);
    chk("t4_busy_cnt", 32'(n_busy), 32'd10);

    // 5: abort by deselect, then a fresh frame
    load(8'h00);
    clr_cnt();
    repeat (3) shift(1'b1);
    RSELIN = 2'd0;
    cyc();
    chk("t5_busy", 32'(busy_m), 32'd0);
    chk("t5_pout", 32'(pout_m), 32'h07);
    RSELIN = 2'd2;
    clr_cnt();
    for (int i = 0; i < 8; i++) shift(i[0]);
    chk("t5_ready_cnt", 32'(n_rdy), 32'd1);
    chk("t5_ready_at", 32'(rdy_at), 32'd8);

    // 6: LOAD beats EN in IDLE; reset mid-frame
    RSELIN = 2'd2; LOAD = 1'b1; EN = 1'b1; PLD = 8'h5A;
    cyc();
    chk("t6_pout", 32'(pout_m), 32'h5A);
    chk("t6_busy", 32'(busy_m), 32'd0);
    quiet();
    repeat (4) shift(1'b1);
    RST = 1'b1;
    cyc();
    chk("t6_rst_pout", 32'(pout_m), 32'h00);
    chk("t6_rst_busy", 32'(busy_m), 32'd0);
    quiet();
    clr_cnt();
    for (int i = 0; i < 8; i++) shift(1'b1);
    chk("t6_ready_at", 32'(rdy_at), 32'd8);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST    = ($urandom_range(0, 99) == 0);
      RSELIN = ($urandom_range(0, 9) < 8) ? 2'd2 : 2'($urandom);
      LOAD   = ($urandom_range(0, 9) == 0);
      EN     = ($urandom_range(0, 9) < 7);
      DI     = 1'($urandom);
      PLD    = 8'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
